// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
// The search is sized for the largest legal requester count (16).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;
  localparam int MAXREQ = 16;
  localparam int PTRW   = 4;

  // First set bit of valid at or after ptr, wrapping at n.
  function automatic logic [PTRW-1:0] rr_pick(
    input logic [MAXREQ-1:0] valid,
    input logic [PTRW-1:0]   ptr,
    input int                n
  );
    logic [PTRW-1:0] sel;
    logic            hit;
    int              t;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      t = k + int'(ptr);
      if (t >= n) t = t - n;
      if (!hit && k < n && valid[t[PTRW-1:0]]) begin
        sel = t[PTRW-1:0];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick_next.sv
// Combinational round-robin priority search: valid vector and pointer
// in, winning index and any-valid flag out.
module rr_pick_next
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            any_valid
);

  assign idx       = IDW'(rr_pick(MAXREQ'(valid), PTRW'(ptr), NREQ));
  assign any_valid = |valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter for the async FIFO write port.
// FIFO_WR_ARB_STATS_EN adds per-requester saturating packet counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DSIZE = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [NREQ*STAT_W-1:0] stat_pkt_cnt
`endif
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_ptr_nxt;
  logic [IDW-1:0]   grant_nxt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             valid_g;
  logic             last_g;
  logic [DSIZE-1:0] data_g;
  logic             accept;
  logic             done;

  rr_pick_next #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign valid_g = req_valid[grant_id];
  assign last_g  = req_last[grant_id];
  assign data_g  = req_data[int'(grant_id)*DSIZE +: DSIZE];
  assign accept  = (state == LOCK) && valid_g && !wfull;
  assign done    = accept && last_g;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        // Only an accepted last beat releases the grant.
        if (done) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    busy      = 1'b0;
    if (state == LOCK) begin
      busy                = 1'b1;
      req_ready[grant_id] = !wfull;
      winc                = valid_g && !wfull;
      wdata               = data_g;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*STAT_W-1:0] stat_q;

  always_ff @(posedge wclk) begin
    if (!wrst_n || stat_clr) begin
      stat_q <= '0;
    end else if (done) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_id == IDW'(i) &&
            stat_q[i*STAT_W +: STAT_W] != '1)
          stat_q[i*STAT_W +: STAT_W] <=
            stat_q[i*STAT_W +: STAT_W] + 1'b1;
      end
    end
  end

  assign stat_pkt_cnt = stat_q;
`endif

  // A stalled requester must hold its beat until it is taken.
  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_hold: assert property (@(posedge wclk) disable iff (!wrst_n)
      (req_valid[i] && !req_ready[i]) ##1 req_valid[i]
      |-> $stable(req_data[i*DSIZE +: DSIZE]));
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Each requester replays a beat list and only advances on acceptance.
module tb_fifo_wr_arbiter;

  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 64;

  logic                  wclk = 1'b0;
  logic                  wrst_n = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull = 1'b0;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic                  stat_clr = 1'b0;
  logic [NREQ*16-1:0]    stat_pkt_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] bdata [NREQ][DEPTH];
  logic       blast [NREQ][DEPTH];
  int         head [NREQ];
  int         cnt [NREQ];
  logic [NREQ-1:0] en = '0;
  logic [NREQ-1:0] acc;
  logic [7:0] wlog [$];
  int         wcyc [$];
  int         cyc = 0;

  fifo_wr_arbiter dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .wfull        (wfull),
    .winc         (winc),
    .wdata        (wdata),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_pkt_cnt (stat_pkt_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      cnt[i] = 0;
    end
  end

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] < cnt[i]) begin
        req_valid[i] = en[i];
        req_data[i*DSIZE +: DSIZE] = bdata[i][head[i]];
        req_last[i] = blast[i][head[i]];
      end
    end
  end

  always @(negedge wclk) begin
    acc = req_valid & req_ready;
    if (winc) begin
      wlog.push_back(wdata);
      wcyc.push_back(cyc);
    end
  end

  always @(posedge wclk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) head[i] = head[i] + 1;
  end

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    bdata[r][cnt[r]] = d;
    blast[r][cnt[r]] = l;
    cnt[r] = cnt[r] + 1;
  endtask

  task automatic do_reset();
    en = '0;
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) cnt[i] = head[i];
    wrst_n = 1'b0;
    tick();
    tick();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    en = '1;
    push(2, 8'h5A, 1'b1);
    tick(); #1;
    checks++;
    if ({busy, winc, req_ready, grant_id, wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b/%b/%b/%0d/%h required 0", busy, winc, req_ready, grant_id, wdata);
    end
    tick(); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_held busy=%b required 0", busy);
    end
    wrst_n = 1'b1;
    tick(); #1;
    checks++;
    if ({busy, winc, grant_id, wdata} !== {1'b1, 1'b1, 2'd2, 8'h5A}) begin
      failures++;
      $display("FAIL first_grant got=%b/%b/%0d/%h required 1/1/2/5a", busy, winc, grant_id, wdata);
    end
    tick(); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_beat_done busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] exp [3];
    int base;
    do_reset();
    exp[0] = 8'hA0; exp[1] = 8'hA1; exp[2] = 8'hA2;
    en[1] = 1'b1;
    push(1, 8'hA0, 1'b0);
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b1);
    base = wlog.size();
    #1;
    checks++;
    if ({busy, winc, req_ready} !== '0) begin
      failures++;
      $display("FAIL idle_cycle got=%b/%b/%b required 0", busy, winc, req_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      checks++;
      if ({busy, winc, grant_id, req_ready, wdata} !== {1'b1, 1'b1, 2'd1, 4'b0010, exp[c-1]}) begin
        failures++;
        $display("FAIL single_c%0d got=%b/%b/%0d/%b/%h required 1/1/1/0010/%h", c, busy, winc, grant_id, req_ready, wdata, exp[c-1]);
      end
    end
    tick(); #1;
    checks++;
    if ({busy, winc, dut.rr_ptr} !== {1'b0, 1'b0, 2'd2}) begin
      failures++;
      $display("FAIL single_end got=%b/%b/ptr%0d required 0/0/ptr2", busy, winc, dut.rr_ptr);
    end
    checks++;
    if (wlog.size() != base + 3) begin
      failures++;
      $display("FAIL single_count got=%0d required 3", wlog.size() - base);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp [10];
    int base;
    int gap;
    do_reset();
    exp = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    for (int i = 0; i < NREQ; i++) begin
      push(i, 8'(i * 16), 1'b0);
      push(i, 8'(i * 16 + 1), 1'b1);
    end
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    en = '1;
    base = wlog.size();
    for (int c = 0; c < 16; c++) tick();
    checks++;
    if (wlog.size() != base + 10) begin
      failures++;
      $display("FAIL rr_count got=%0d required 10", wlog.size() - base);
    end else begin
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (wlog[base+j] !== exp[j]) begin
          failures++;
          $display("FAIL rr_order_%0d got=%h required %h", j, wlog[base+j], exp[j]);
        end
      end
      for (int j = 1; j < 10; j++) begin
        gap = wcyc[base+j] - wcyc[base+j-1];
        checks++;
        if (gap != ((j % 2 == 1) ? 1 : 2)) begin
          failures++;
          $display("FAIL rr_gap_%0d got=%0d required %0d", j, gap, (j % 2 == 1) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_full_hold();
    logic [7:0] exp [4];
    int base;
    do_reset();
    exp = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    en[2] = 1'b1;
    for (int k = 0; k < 4; k++) push(2, exp[k], k == 3);
    base = wlog.size();
    tick(); #1;
    checks++;
    if ({winc, wdata} !== {1'b1, 8'hC0}) begin
      failures++;
      $display("FAIL full_c1 got=%b/%h required 1/c0", winc, wdata);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      wfull = 1'b1;
      #1;
      checks++;
      if ({busy, winc, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
        failures++;
        $display("FAIL full_stall_c%0d got=%b/%b/%b required 1/0/0000", c, busy, winc, req_ready);
      end
    end
    tick();
    wfull = 1'b0;
    #1;
    checks++;
    if ({winc, req_ready, wdata} !== {1'b1, 4'b0100, 8'hC1}) begin
      failures++;
      $display("FAIL full_resume got=%b/%b/%h required 1/0100/c1", winc, req_ready, wdata);
    end
    tick();
    tick();
    wfull = 1'b1;
    #1;
    checks++;
    if ({winc, req_last[2]} !== {1'b0, 1'b1}) begin
      failures++;
      $display("FAIL full_last_block got=%b/%b required 0/1", winc, req_last[2]);
    end
    tick();
    wfull = 1'b0;
    #1;
    checks++;
    if ({busy, grant_id, winc, wdata} !== {1'b1, 2'd2, 1'b1, 8'hC3}) begin
      failures++;
      $display("FAIL full_last_retry got=%b/%0d/%b/%h required 1/2/1/c3", busy, grant_id, winc, wdata);
    end
    tick(); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL full_end busy=%b required 0", busy);
    end
    checks++;
    if (wlog.size() != base + 4) begin
      failures++;
      $display("FAIL full_count got=%0d required 4", wlog.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wlog[base+k] !== exp[k]) begin
          failures++;
          $display("FAIL full_order_%0d got=%h required %h", k, wlog[base+k], exp[k]);
        end
      end
      checks++;
      if (wcyc[base+1] - wcyc[base] != 5) begin
        failures++;
        $display("FAIL full_gap got=%0d required 5", wcyc[base+1] - wcyc[base]);
      end
    end
  endtask

  task automatic test_valid_drop();
    logic [7:0] exp [4];
    int base;
    do_reset();
    exp = '{8'hD0, 8'hD1, 8'hD2, 8'hE0};
    en = 4'b1001;
    push(0, 8'hD0, 1'b0);
    push(0, 8'hD1, 1'b0);
    push(0, 8'hD2, 1'b1);
    push(3, 8'hE0, 1'b1);
    base = wlog.size();
    tick(); #1;
    checks++;
    if ({grant_id, winc, wdata} !== {2'd0, 1'b1, 8'hD0}) begin
      failures++;
      $display("FAIL drop_first got=%0d/%b/%h required 0/1/d0", grant_id, winc, wdata);
    end
    for (int c = 2; c <= 11; c++) begin
      tick();
      en[0] = 1'b0;
      #1;
      checks++;
      if ({busy, grant_id, winc} !== {1'b1, 2'd0, 1'b0}) begin
        failures++;
        $display("FAIL drop_wait_c%0d got=%b/%0d/%b required 1/0/0", c, busy, grant_id, winc);
      end
    end
    tick();
    en[0] = 1'b1;
    tick();
    tick(); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_bubble busy=%b required 0", busy);
    end
    tick(); #1;
    checks++;
    if ({grant_id, winc, wdata} !== {2'd3, 1'b1, 8'hE0}) begin
      failures++;
      $display("FAIL drop_next got=%0d/%b/%h required 3/1/e0", grant_id, winc, wdata);
    end
    tick();
    checks++;
    if (wlog.size() != base + 4) begin
      failures++;
      $display("FAIL drop_count got=%0d required 4", wlog.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wlog[base+k] !== exp[k]) begin
          failures++;
          $display("FAIL drop_order_%0d got=%h required %h", k, wlog[base+k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    en[2] = 1'b1;
    push(2, 8'h21, 1'b1);
    push(2, 8'h22, 1'b0);
    push(2, 8'h23, 1'b0);
    push(2, 8'h24, 1'b1);
    tick();
    tick();
    tick();
    tick();
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({busy, grant_id, winc} !== {1'b1, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL rst_setup got=%b/%0d/%b required 1/2/1", busy, grant_id, winc);
    end
    tick();
    wrst_n = 1'b1;
    en = 4'b1010;
    push(1, 8'h11, 1'b1);
    push(3, 8'h31, 1'b1);
    #1;
    checks++;
    if ({busy, winc, req_ready, dut.rr_ptr} !== '0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%b/%b/ptr%0d required 0", busy, winc, req_ready, dut.rr_ptr);
    end
    tick(); #1;
    checks++;
    if ({grant_id, winc, wdata} !== {2'd1, 1'b1, 8'h11}) begin
      failures++;
      $display("FAIL rst_regrant got=%0d/%b/%h required 1/1/11", grant_id, winc, wdata);
    end
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    en[1] = 1'b1;
    for (int k = 0; k < 3; k++) push(1, 8'(8'h40 + k), 1'b1);
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (stat_pkt_cnt[31:0] !== 32'h0003_0000) begin
      failures++;
      $display("FAIL stat_count got=%h required 00030000", stat_pkt_cnt[31:0]);
    end
    push(1, 8'h50, 1'b1);
    tick();
    stat_clr = 1'b1;
    #1;
    checks++;
    if (winc !== 1'b1) begin
      failures++;
      $display("FAIL stat_clr_beat winc=%b required 1", winc);
    end
    tick();
    stat_clr = 1'b0;
    #1;
    checks++;
    if (stat_pkt_cnt[31:16] !== 16'h0000) begin
      failures++;
      $display("FAIL stat_clr_wins got=%h required 0000", stat_pkt_cnt[31:16]);
    end
    force dut.stat_q = 64'h0000_0000_FFFF_0000;
    #1;
    release dut.stat_q;
    push(1, 8'h60, 1'b1);
    tick();
    tick();
    tick(); #1;
    checks++;
    if (stat_pkt_cnt[31:16] !== 16'hFFFF) begin
      failures++;
      $display("FAIL stat_saturate got=%h required ffff", stat_pkt_cnt[31:16]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_hold();
    test_valid_drop();
    test_reset_mid_packet();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
